// File: rtl/cmp_result_tracker.sv
// rtl/cmp_result_tracker.sv - debounces comparator flags into a qualified result with raw sample counters.
// Optional macro CMP_ONEHOT_CHECK_EN: reject non-one-hot flag samples and pulse err.
module cmp_result_tracker #(
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             A_greater,
  input  logic             A_equal,
  input  logic             A_less,
  input  logic             clr,
  output logic [1:0]       result,
  output logic             result_valid,
  output logic             change_pulse,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, QUALIFY, STABLE} state_t;

  localparam logic [3:0]       RUN_TGT = 4'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_nx;
  logic [1:0] cand, cand_nx;
  logic [3:0] run, run_nx;
  logic [1:0] result_nx;
  logic       result_valid_nx;
  logic       change_nx;
  logic [1:0] code;
  logic       malformed;
  logic       take;

  assign take = valid_in && !clr;

  always_comb begin
    malformed = 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
    malformed = !({A_greater, A_equal, A_less} == 3'b100 ||
                  {A_greater, A_equal, A_less} == 3'b010 ||
                  {A_greater, A_equal, A_less} == 3'b001);
`endif
    if (malformed)      code = 2'b00;
    else if (A_greater) code = 2'b11;
    else if (A_equal)   code = 2'b10;
    else if (A_less)    code = 2'b01;
    else                code = 2'b00;
  end

  always_comb begin
    state_nx        = state;
    cand_nx         = cand;
    run_nx          = run;
    result_nx       = result;
    result_valid_nx = result_valid;
    change_nx       = 1'b0;
    if (clr) begin
      state_nx        = IDLE;
      cand_nx         = 2'b00;
      run_nx          = 4'd0;
      result_nx       = 2'b00;
      result_valid_nx = 1'b0;
    end else if (valid_in) begin
      case (state)
        IDLE: begin
          if (code != 2'b00) begin
            state_nx = QUALIFY;
            cand_nx  = code;
            run_nx   = 4'd1;
          end
        end
        QUALIFY: begin
          if (code == cand) begin
            run_nx = run + 4'd1;
            if (run + 4'd1 == RUN_TGT) begin
              state_nx        = STABLE;
              result_nx       = cand;
              result_valid_nx = 1'b1;
              // result is 00 after reset/clr, so the first qualification always differs
              change_nx       = (cand != result);
            end
          end else if (code != 2'b00) begin
            cand_nx = code;
            run_nx  = 4'd1;
          end else begin
            state_nx = IDLE;
            run_nx   = 4'd0;
          end
        end
        STABLE: begin
          if (code != 2'b00 && code != result) begin
            state_nx = QUALIFY;
            cand_nx  = code;
            run_nx   = 4'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cand         <= 2'b00;
      run          <= 4'd0;
      result       <= 2'b00;
      result_valid <= 1'b0;
      change_pulse <= 1'b0;
    end else begin
      state        <= state_nx;
      cand         <= cand_nx;
      run          <= run_nx;
      result       <= result_nx;
      result_valid <= result_valid_nx;
      change_pulse <= change_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_count <= '0;
      eq_count <= '0;
      lt_count <= '0;
    end else if (clr) begin
      gt_count <= '0;
      eq_count <= '0;
      lt_count <= '0;
    end else if (take) begin
      if (code == 2'b11 && gt_count != CNT_MAX) gt_count <= gt_count + 1'b1;
      if (code == 2'b10 && eq_count != CNT_MAX) eq_count <= eq_count + 1'b1;
      if (code == 2'b01 && lt_count != CNT_MAX) lt_count <= lt_count + 1'b1;
    end
  end

`ifdef CMP_ONEHOT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= take && malformed;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb/tb_cmp_result_tracker.sv - scoreboard bench for cmp_result_tracker (default and CNT_W=2 instances).
module tb_cmp_result_tracker;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0, A_greater = 1'b0, A_equal = 1'b0, A_less = 1'b0, clr = 1'b0;

  logic [1:0] result, result2;
  logic       result_valid, result_valid2, change_pulse, change_pulse2, err, err2;
  logic [7:0] gt_count, eq_count, lt_count;
  logic [1:0] gt2, eq2, lt2;

  cmp_result_tracker #(.STABLE_CNT(N), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .A_greater(A_greater), .A_equal(A_equal),
    .A_less(A_less), .clr(clr), .result(result), .result_valid(result_valid),
    .change_pulse(change_pulse), .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
    .err(err));

  cmp_result_tracker #(.STABLE_CNT(N), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .A_greater(A_greater), .A_equal(A_equal),
    .A_less(A_less), .clr(clr), .result(result2), .result_valid(result_valid2),
    .change_pulse(change_pulse2), .gt_count(gt2), .eq_count(eq2), .lt_count(lt2),
    .err(err2));

  always #5 clk = ~clk;

  typedef struct {
    int res, rv, cp, er;
    int gt, eq, lt;
    int gts, eqs, lts;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int n_checks = 0;
  int n_fail = 0;

  // reference model: a streak of identical nonzero codes qualifies at length N
  int m_phase;      // 0 nothing pending, 1 building a streak, 2 holding a qualified result
  int m_streak_code, m_streak_len, m_res, m_rv;
  int m_gt, m_eq, m_lt, m_gts, m_eqs, m_lts;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_streak_code = 0; m_streak_len = 0; m_res = 0; m_rv = 0;
    m_gt = 0; m_eq = 0; m_lt = 0; m_gts = 0; m_eqs = 0; m_lts = 0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  function automatic exp_t model_step(input bit v, input bit g, input bit e, input bit l, input bit c);
    exp_t x;
    int code;
    bit bad;
    x.cp = 0; x.er = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      bad = 0;
`ifdef CMP_ONEHOT_CHECK_EN
      bad = (int'(g) + int'(e) + int'(l)) != 1;
`endif
      code = bad ? 0 : g ? 3 : e ? 2 : l ? 1 : 0;
      x.er = bad;
      if (code == 3) begin m_gt = sat(m_gt, 255); m_gts = sat(m_gts, 3); end
      if (code == 2) begin m_eq = sat(m_eq, 255); m_eqs = sat(m_eqs, 3); end
      if (code == 1) begin m_lt = sat(m_lt, 255); m_lts = sat(m_lts, 3); end
      if (m_phase == 2) begin
        if (code != 0 && code != m_res) begin
          m_phase = 1; m_streak_code = code; m_streak_len = 1;
        end
      end else if (code == 0) begin
        m_phase = 0; m_streak_len = 0;
      end else if (m_phase == 1 && code == m_streak_code) begin
        m_streak_len++;
        if (m_streak_len == N) begin
          x.cp = (m_res != code);
          m_res = code; m_rv = 1; m_phase = 2;
        end
      end else begin
        m_phase = 1; m_streak_code = code; m_streak_len = 1;
      end
    end
    x.res = m_res; x.rv = m_rv;
    x.gt = m_gt; x.eq = m_eq; x.lt = m_lt;
    x.gts = m_gts; x.eqs = m_eqs; x.lts = m_lts;
    return x;
  endfunction

  task automatic drive(input bit v, input bit g, input bit e, input bit l, input bit c);
    @(negedge clk);
    valid_in = v; A_greater = g; A_equal = e; A_less = l; clr = c;
    q.push_back(model_step(v, g, e, l, c));
    @(posedge clk);
    #2;
    valid_in = 1'b0; clr = 1'b0;
  endtask

  task automatic check_internal(input string tag);
    chk({tag, "_cand"}, int'(dut.cand), m_streak_code);
    chk({tag, "_run"}, int'(dut.run), m_streak_len);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_rv"}, int'(result_valid), 0);
    chk({tag, "_cp"}, int'(change_pulse), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_gt"}, int'(gt_count), 0);
    chk({tag, "_eq"}, int'(eq_count), 0);
    chk({tag, "_lt"}, int'(lt_count), 0);
    chk({tag, "_run"}, int'(dut.run), 0);
    chk({tag, "_cand"}, int'(dut.cand), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_x = q.pop_front();
        chk("result", int'(result), mon_x.res);
        chk("result_valid", int'(result_valid), mon_x.rv);
        chk("change_pulse", int'(change_pulse), mon_x.cp);
        chk("err", int'(err), mon_x.er);
        chk("gt_count", int'(gt_count), mon_x.gt);
        chk("eq_count", int'(eq_count), mon_x.eq);
        chk("lt_count", int'(lt_count), mon_x.lt);
        chk("sat_result", int'(result2), mon_x.res);
        chk("sat_gt", int'(gt2), mon_x.gts);
        chk("sat_eq", int'(eq2), mon_x.eqs);
        chk("sat_lt", int'(lt2), mon_x.lts);
      end
    end
  end

  logic [2:0] flags;

  initial begin
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // three greater samples qualify 11
    repeat (3) drive(1, 1, 0, 0, 0);
    chk("d1_result", int'(result), 3);
    chk("d1_gt", int'(gt_count), 3);
    drive(0, 0, 0, 0, 0);

    // less, less, equal from STABLE 11
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 1, 0, 0);
    check_internal("d2");
    chk("d2_result", int'(result), 3);

    // gapped equal samples still qualify on the third
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(i % 2 == 0, 0, 1, 0, 0);
    chk("d3_result", int'(result), 2);

    // clr wins over a simultaneous greater sample
    drive(1, 1, 0, 0, 1);
    chk("d4_gt", int'(gt_count), 0);
    chk("d4_rv", int'(result_valid), 0);

    // CNT_W=2 instance saturates at 3
    repeat (5) drive(1, 0, 1, 0, 0);
    chk("d5_eq_sat", int'(eq2), 3);

    // malformed flags in QUALIFY
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    check_internal("d6");

    // async reset mid-qualification
    drive(1, 0, 0, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero("areset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    flags = 3'b100;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 25) flags = 3'($urandom_range(0, 7));
      drive($urandom_range(0, 99) < 80, flags[2], flags[1], flags[0],
            $urandom_range(0, 99) < 2);
    end
    check_internal("rand_end");
    if (q.size() != 0) chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
CMP_RESULT_TRACKER -- requirements
Module: cmp_result_tracker

Interface
REQ-001 The block SHALL have parameter STABLE_CNT, default 3, giving the number of consecutive identical valid samples needed to qualify a result (legal range 2..15).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each occurrence counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port valid_in, input, 1 bit: comparator flags are valid this cycle.
REQ-006 The block SHALL have ports A_greater, A_equal and A_less, each an input of 1 bit: comparator flags.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-008 The block SHALL have port result, output, 2 bits: qualified result (00 none, 01 less, 10 equal, 11 greater).
REQ-009 The block SHALL have port result_valid, output, 1 bit: result holds a qualified value.
REQ-010 The block SHALL have port change_pulse, output, 1 bit: one-cycle pulse on a new qualified result.
REQ-011 The block SHALL have ports gt_count, eq_count and lt_count, each an output of CNT_W bits: raw sample counters.
REQ-012 The block SHALL have port err, output, 1 bit: malformed-flag pulse (see Configuration).

Function
REQ-013 The block SHALL encode each sample with priority: greater -> 11, else equal -> 10, else less -> 01, else 00.
REQ-014 All outputs SHALL be registered, and a sample taken at edge N SHALL affect outputs after edge N.
REQ-015 FSM states SHALL be IDLE, QUALIFY and STABLE, with internal registers cand (2 bits) and run (4 bits).
REQ-016 In IDLE, a nonzero valid sample SHALL move the FSM to QUALIFY with cand = code and run = 1.
REQ-017 In QUALIFY, a sample equal to cand SHALL increment run, and when run reaches STABLE_CNT the FSM SHALL enter STABLE with result = cand and result_valid = 1.
REQ-018 In QUALIFY, a differing nonzero sample SHALL restart qualification with cand = code and run = 1.
REQ-019 In QUALIFY, code 00 SHALL return the FSM to IDLE with run = 0, and result/result_valid SHALL hold their prior values.
REQ-020 In STABLE, a sample equal to result SHALL leave the FSM in STABLE.
REQ-021 In STABLE, a differing nonzero sample SHALL move the FSM to QUALIFY with run = 1, and the old result SHALL stay visible with result_valid = 1.
REQ-022 In STABLE, code 00 SHALL be ignored.
REQ-023 change_pulse SHALL assert for exactly one cycle, coincident with result update, only when the new qualified result differs from the previous result, and the first qualification after reset or clr SHALL count as a change.
REQ-024 When valid_in = 0, state, cand, run and counters SHALL hold.
REQ-025 Each valid sample SHALL increment the counter matching its code (11 -> gt, 10 -> eq, 01 -> lt), independent of FSM state.
REQ-026 Each counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 clr SHALL zero all counters, result, result_valid, change_pulse, run and cand, and SHALL force the FSM to IDLE.
REQ-028 clr SHALL win over a simultaneous valid sample, and that sample SHALL be dropped and not counted.

Reset
REQ-029 rst_n low SHALL asynchronously force the FSM to IDLE; result = 00; result_valid, change_pulse and err = 0; run, cand and all counters = 0.
REQ-030 Reset assertion mid-qualification SHALL discard all progress, and deassertion SHALL take effect synchronously to clk.

Configuration
REQ-031 When macro CMP_ONEHOT_CHECK_EN is defined, a valid sample whose flags are not exactly one-hot SHALL pulse err for one cycle, SHALL be treated as code 00 by the FSM, and SHALL not be counted.
REQ-032 When CMP_ONEHOT_CHECK_EN is undefined, err SHALL be tied 0 and the REQ-013 priority encoding SHALL apply to all samples.

Verification
REQ-033 The bench SHALL cover: reset, then three valid samples of (1,0,0) -> result = 11 and result_valid = 1 after edge 3; change_pulse high one cycle; gt_count = 3.
REQ-034 The bench SHALL cover: from STABLE 11, samples less, less, equal -> result stays 11; FSM ends in QUALIFY with cand = 10, run = 1; lt_count = 2, eq_count = 1.
REQ-035 The bench SHALL cover: valid_in toggled 1,0,1,0,1 with equal flags -> qualifies 10 on the third valid sample; idle cycles do not reset run.
REQ-036 The bench SHALL cover: clr asserted with a simultaneous valid greater sample -> counters = 0, result = 00, result_valid = 0, gt_count not incremented.
REQ-037 The bench SHALL cover: CNT_W = 2 with five valid equal samples -> eq_count saturates at 3.
REQ-038 The bench SHALL cover: with CMP_ONEHOT_CHECK_EN, sample (1,1,0) in QUALIFY -> err pulses, FSM returns to IDLE, no counter changes; without the macro the same sample counts as greater.
